data_ram_slave: RTL and testbench
=================================

Name: data_ram_slave

Overview:
- Data-memory responder for the 5-stage pipeline; answers the MEM stage's dm_addr/dm_wen/dm_wdata requests.
- Returns dm_rdata with one-beat synchronous read latency; MEM stage relies on exactly one beat for loads.
- Contains a word-organised RAM with per-byte write enables, plus a small MMIO window: free-running cycle counter and an LED register.
- Provides a second read-only debug port for the board display.

Parameters:
- DEPTH_LOG2, 8, RAM holds 2**DEPTH_LOG2 32-bit words (default 1 KiB).
- MMIO_BASE, 32'hFFFF_0000, base of MMIO window; offset 0x0 = counter, 0x4 = LED register.

Ports:
- clk  in  1  system clock, all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- dm_addr  in  32  byte address from MEM stage.
- dm_wen  in  4  byte write enables; bit i writes byte lane i (bits 8i+7:8i).
- dm_wdata  in  32  write data, already lane-aligned by requester.
- dm_rdata  out  32  read data for the address presented on the previous edge.
- dm_err  out  1  registered pulse: previous-beat access hit an unmapped address.
- dbg_addr  in  32  debug read byte address.
- dbg_rdata  out  32  debug read data, one-beat latency, RAM region only.
- led  out  16  LED register bits [15:0].

Behaviour:
- Async reset (resetn low): dm_rdata=0, dbg_rdata=0, dm_err=0, cycle counter=0, LED register=0. RAM contents not reset and not cleared.
- Address decode:
  - RAM hit: dm_addr[31:DEPTH_LOG2+2]==0.
  - Word index: dm_addr[DEPTH_LOG2+1:2]. dm_addr[1:0] is ignored; lane selection comes only from dm_wen.
  - MMIO hit: dm_addr[31:3]==MMIO_BASE[31:3]; dm_addr[2] selects counter (0) or LED register (1).
  - Otherwise unmapped.
- Write (posedge, any dm_wen bit set):
  - RAM hit: only enabled byte lanes of the addressed word update.
  - LED register: enabled lanes update; only [15:0] is stored, so lanes 2/3 are ignored.
  - Counter: read-only; writes ignored.
  - Unmapped: no state change.
- Read (every posedge, regardless of dm_wen):
  - dm_rdata <= RAM word, counter value, {16'b0, LED} or 32'b0, according to decode.
  - Latency exactly 1 beat; dm_rdata holds until the next edge.
- Read-during-write, same RAM word or LED register, same edge: dm_rdata returns the OLD contents (read-first).
- Counter:
  - Increments by 1 every posedge after reset; wraps 32'hFFFF_FFFF -> 0.
  - A read on edge N returns the value held just before edge N.
- dm_err <= 1 on the edge following an edge at which the address was unmapped and either dm_wen!=0 or a read was sampled.
  - The MEM stage always presents an address, so unmapped idle addresses also flag.
  - dm_err is cleared on the next edge unless re-triggered.
- Debug port:
  - dbg_rdata <= RAM word at dbg_addr[DEPTH_LOG2+1:2] each edge if dbg_addr is in RAM range, else 0.
  - Read-first against a simultaneous dm write to the same word.
  - No effect on dm_* paths.
- Reset mid-operation: a write at the same edge as resetn assertion is not guaranteed to take effect. Outputs are forced to reset values asynchronously.

Optional Feature:
- Macro DM_WRITE_FIRST_EN.
- Defined: RAM and LED read-during-write is write-first.
  - dm_rdata returns the merged word: written lanes from dm_wdata, other lanes from old contents.
  - The same rule applies to dbg_rdata when dbg_addr hits the written word.
- Undefined: read-first as specified above.
- Counter and unmapped behaviour are identical in both builds.

Test Plan:
- Reset then idle at dm_addr=0x0, dm_wen=0 -> dm_rdata=0, dm_err=0. After 5 edges, reading MMIO_BASE returns 4 (counter value before the 5th sampling edge, counting from first edge after reset = 0).
- Write 0x1122_3344 to 0x10 with wen=4'b1111, then read 0x10 -> dm_rdata=0x1122_3344 exactly one edge after the address is presented.
- Byte write wen=4'b0100, wdata=0x00AB_0000 at 0x10, then read -> 0x11AB_3344. Same data with wen=4'b0000 -> unchanged.
- Same-edge write 0xDEAD_BEEF (wen=1111) and read of 0x10 holding 0x11AB_3344:
  - Default build -> dm_rdata=0x11AB_3344.
  - DM_WRITE_FIRST_EN build -> 0xDEAD_BEEF.
  - Next edge -> 0xDEAD_BEEF in both.
- Write 0xFFFF_A5A5 to MMIO_BASE+4 -> led=0xA5A5 and readback 0x0000_A5A5. Write to MMIO_BASE -> counter continues incrementing, no jump.
- Access 0x0001_0000 with wen=1111 -> dm_err=1 for exactly one beat, dm_rdata=0, RAM word 0 unchanged. Assert resetn low mid-run -> led=0 and counter=0 immediately.

Source files
------------

// File: rtl/data_ram_if.sv
// Data-memory bus between the MEM stage (master) and the data RAM slave.
// Signals:
//   dm_addr   byte address from MEM stage
//   dm_wen    per-byte write enables (bit i -> lane i)
//   dm_wdata  lane-aligned write data
//   dm_rdata  read data, one beat after the address was presented
//   dm_err    one-beat pulse after an access to an unmapped address
//   dbg_addr  debug read byte address (board display)
//   dbg_rdata debug read data, RAM region only, one-beat latency
//   led       LED register bits
interface data_ram_if;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wen;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_rdata;
   logic [15:0] led;

   modport master (
      output dm_addr, dm_wen, dm_wdata, dbg_addr,
      input  dm_rdata, dm_err, dbg_rdata, led
   );

   modport slave (
      input  dm_addr, dm_wen, dm_wdata, dbg_addr,
      output dm_rdata, dm_err, dbg_rdata, led
   );
endinterface

// File: rtl/data_ram_slave.sv
// Data-memory responder for the MEM stage: word RAM with byte enables,
// MMIO window (free-running cycle counter at +0x0, LED register at +0x4)
// and a read-only debug port into the RAM.
// Ports:
//   clk     system clock, all state on posedge
//   resetn  asynchronous active-low reset
//   bus     data_ram_if.slave (dm_*, dbg_*, led)
// Build option:
//   DM_WRITE_FIRST_EN  when defined, RAM/LED read-during-write returns the
//                      merged (new) word; otherwise the old contents.
module data_ram_slave #(
   parameter int          DEPTH_LOG2 = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input logic        clk,
   input logic        resetn,
   data_ram_if.slave  bus
);

   localparam int AW = DEPTH_LOG2;

   // RAM is deliberately not reset; contents survive resetn.
   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] cnt_q;
   logic [15:0] led_q;

   logic          ram_hit, mmio_hit, cnt_sel, led_sel, unmapped, dbg_hit;
   logic [AW-1:0] widx, didx;
   logic [31:0]   ram_old, dbg_old;
   logic [31:0]   ram_rd, dbg_rd, led_rd;
   logic [15:0]   led_next;
   logic [31:0]   rd_next, dbg_next;
   logic          unused_addr_bits;

   assign ram_hit  = (bus.dm_addr[31:AW+2] == '0);
   assign mmio_hit = (bus.dm_addr[31:3] == MMIO_BASE[31:3]);
   assign cnt_sel  = mmio_hit & ~bus.dm_addr[2];
   assign led_sel  = mmio_hit &  bus.dm_addr[2];
   assign unmapped = ~ram_hit & ~mmio_hit;
   assign dbg_hit  = (bus.dbg_addr[31:AW+2] == '0);
   assign widx     = bus.dm_addr[AW+1:2];
   assign didx     = bus.dbg_addr[AW+1:2];
   assign ram_old  = mem[widx];
   assign dbg_old  = mem[didx];

   // Byte offsets are ignored; lanes come only from dm_wen.
   assign unused_addr_bits = ^{bus.dm_addr[1:0], bus.dbg_addr[1:0]};

   // Only lanes 0/1 exist in the LED register.
   always_comb begin
      led_next = led_q;
      if (bus.dm_wen[0]) led_next[7:0]  = bus.dm_wdata[7:0];
      if (bus.dm_wen[1]) led_next[15:8] = bus.dm_wdata[15:8];
   end

`ifdef DM_WRITE_FIRST_EN
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  en);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++)
         if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Non-RAM dm addresses never write RAM, so the debug bypass needs ram_hit.
   assign ram_rd = merge_lanes(ram_old, bus.dm_wdata, bus.dm_wen);
   assign dbg_rd = (ram_hit && didx == widx) ?
                   merge_lanes(dbg_old, bus.dm_wdata, bus.dm_wen) : dbg_old;
   assign led_rd = {16'h0000, led_next};
`else
   assign ram_rd = ram_old;
   assign dbg_rd = dbg_old;
   assign led_rd = {16'h0000, led_q};
`endif

   always_comb begin
      rd_next = 32'h0;
      if (ram_hit)      rd_next = ram_rd;
      else if (cnt_sel) rd_next = cnt_q;
      else if (led_sel) rd_next = led_rd;
   end

   assign dbg_next = dbg_hit ? dbg_rd : 32'h0;

   always_ff @(posedge clk) begin
      if (ram_hit) begin
         for (int i = 0; i < 4; i++)
            if (bus.dm_wen[i]) mem[widx][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q         <= 32'h0;
         led_q         <= 16'h0;
         bus.dm_rdata  <= 32'h0;
         bus.dbg_rdata <= 32'h0;
         bus.dm_err    <= 1'b0;
      end else begin
         cnt_q         <= cnt_q + 32'd1;
         if (led_sel) led_q <= led_next;
         bus.dm_rdata  <= rd_next;
         bus.dbg_rdata <= dbg_next;
         // Every beat samples a read, so any unmapped address flags.
         bus.dm_err    <= unmapped;
      end
   end

   assign bus.led = led_q;

endmodule

// File: tb/tb_data_ram_slave.sv
module tb_data_ram_slave;
   localparam int          DL    = 8;
   localparam int          WORDS = 1 << DL;
   localparam logic [31:0] MB    = 32'hFFFF_0000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   data_ram_if bus();
   data_ram_slave #(.DEPTH_LOG2(DL), .MMIO_BASE(MB)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [WORDS];
   bit          ref_valid [WORDS];
   logic [31:0] ref_cnt;
   logic [15:0] ref_led;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] en);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++)
         if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // 0 = RAM, 1 = counter, 2 = LED, 3 = unmapped
   function automatic int region(input logic [31:0] a);
      if (a < 32'(WORDS * 4)) return 0;
      if (a >= MB && (a - MB) < 32'd4) return 1;
      if (a >= MB && (a - MB) < 32'd8) return 2;
      return 3;
   endfunction

   // One clock edge: predict outputs from model state and current inputs,
   // advance the model, then compare just after the edge.
   task automatic step();
      logic [31:0] a, w, d, exp_rd, exp_dbg, tmp;
      logic [3:0]  en;
      logic        exp_err, rd_known, dbg_known;
      int          r, idx, di;
      a = bus.dm_addr; w = bus.dm_wdata; d = bus.dbg_addr; en = bus.dm_wen;
      r = region(a);
      idx = int'((a >> 2) % WORDS);
      exp_err = (r == 3);
      rd_known = 1'b1;
      exp_rd = 32'h0;
      case (r)
         0: begin
            exp_rd = ref_mem[idx];
            rd_known = ref_valid[idx];
`ifdef DM_WRITE_FIRST_EN
            exp_rd = lanes(ref_mem[idx], w, en);
            rd_known = ref_valid[idx] || en == 4'hF;
`endif
         end
         1: exp_rd = ref_cnt;
         2: begin
            exp_rd = {16'h0, ref_led};
`ifdef DM_WRITE_FIRST_EN
            tmp = lanes({16'h0, ref_led}, w, en);
            exp_rd = {16'h0, tmp[15:0]};
`endif
         end
         default: exp_rd = 32'h0;
      endcase
      dbg_known = 1'b1;
      exp_dbg = 32'h0;
      if (d < 32'(WORDS * 4)) begin
         di = int'((d >> 2) % WORDS);
         exp_dbg = ref_mem[di];
         dbg_known = ref_valid[di];
`ifdef DM_WRITE_FIRST_EN
         if (r == 0 && di == idx) begin
            exp_dbg = lanes(ref_mem[di], w, en);
            dbg_known = ref_valid[di] || en == 4'hF;
         end
`endif
      end
      @(posedge clk);
      if (r == 0 && en != 4'h0) begin
         ref_mem[idx] = lanes(ref_mem[idx], w, en);
         if (en == 4'hF) ref_valid[idx] = 1'b1;
      end
      if (r == 2) begin
         tmp = lanes({16'h0, ref_led}, w, en);
         ref_led = tmp[15:0];
      end
      ref_cnt = ref_cnt + 32'd1;
      #1;
      if (rd_known) check("dm_rdata", bus.dm_rdata, exp_rd);
      check("dm_err", {31'b0, bus.dm_err}, {31'b0, exp_err});
      if (dbg_known) check("dbg_rdata", bus.dbg_rdata, exp_dbg);
      check("led", {16'h0, bus.led}, {16'h0, ref_led});
   endtask

   task automatic drive(input logic [31:0] a, input logic [3:0] en, input logic [31:0] w);
      bus.dm_addr = a; bus.dm_wen = en; bus.dm_wdata = w;
   endtask

   initial begin
      logic [31:0] v1, v2, word0, exp_same, ra;
      int sel;
      for (int i = 0; i < WORDS; i++) begin ref_mem[i] = 32'h0; ref_valid[i] = 1'b0; end
      ref_cnt = 32'h0; ref_led = 16'h0;
      drive(32'h0, 4'h0, 32'h0);
      bus.dbg_addr = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", bus.dm_rdata, 32'h0);
      check("rst_err", {31'b0, bus.dm_err}, 32'h0);
      check("rst_dbg", bus.dbg_rdata, 32'h0);
      check("rst_led", {16'h0, bus.led}, 32'h0);
      @(negedge clk) resetn = 1'b1;

      // Counter: four idle edges, read on the fifth returns 4
      repeat (4) step();
      drive(MB, 4'h0, 32'h0);
      step();
      check("cnt_after_5", bus.dm_rdata, 32'd4);

      // Fill RAM with random words
      for (int i = 0; i < WORDS; i++) begin
         drive(32'(i * 4), 4'hF, $urandom);
         bus.dbg_addr = 32'($urandom_range(0, WORDS * 4 - 1));
         step();
      end

      // Full write then read
      drive(32'h10, 4'hF, 32'h1122_3344); step();
      drive(32'h10, 4'h0, 32'h0); step();
      check("rd_full", bus.dm_rdata, 32'h1122_3344);
      // Byte lane write
      drive(32'h10, 4'b0100, 32'h00AB_0000); step();
      drive(32'h10, 4'h0, 32'h00AB_0000); step();
      check("rd_byte", bus.dm_rdata, 32'h11AB_3344);
      step();
      check("rd_wen0", bus.dm_rdata, 32'h11AB_3344);
      // Same-edge read/write, debug port watching the same word
      bus.dbg_addr = 32'h12;
      drive(32'h13, 4'hF, 32'hDEAD_BEEF); step();
`ifdef DM_WRITE_FIRST_EN
      exp_same = 32'hDEAD_BEEF;
`else
      exp_same = 32'h11AB_3344;
`endif
      check("rdw_same", bus.dm_rdata, exp_same);
      check("rdw_dbg", bus.dbg_rdata, exp_same);
      drive(32'h10, 4'h0, 32'h0); step();
      check("rdw_next", bus.dm_rdata, 32'hDEAD_BEEF);
      check("rdw_dbg_next", bus.dbg_rdata, 32'hDEAD_BEEF);

      // LED register
      drive(MB + 32'h4, 4'hF, 32'hFFFF_A5A5); step();
      check("led_val", {16'h0, bus.led}, 32'h0000_A5A5);
      drive(MB + 32'h4, 4'h0, 32'h0); step();
      check("led_rd", bus.dm_rdata, 32'h0000_A5A5);
      // Counter ignores writes
      drive(MB, 4'hF, 32'h0); step();
      v1 = bus.dm_rdata;
      drive(MB, 4'hF, 32'hFFFF_FFFF); step();
      v2 = bus.dm_rdata;
      check("cnt_no_jump", v2 - v1, 32'd1);

      // Unmapped access
      word0 = ref_mem[0];
      drive(32'h0001_0000, 4'hF, $urandom); step();
      check("unm_err", {31'b0, bus.dm_err}, 32'd1);
      check("unm_rdata", bus.dm_rdata, 32'h0);
      drive(32'h0, 4'h0, 32'h0); step();
      check("unm_err_clr", {31'b0, bus.dm_err}, 32'd0);
      check("unm_word0", bus.dm_rdata, word0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      ra = 32'($urandom_range(0, WORDS * 4 - 1));
         else if (sel < 8) ra = MB + 32'($urandom_range(0, 7));
         else              ra = 32'h0000_0400 + 32'($urandom_range(0, 32'h00FF_0000));
         drive(ra, 4'($urandom_range(0, 15)), $urandom);
         bus.dbg_addr = ($urandom_range(0, 3) == 0) ? $urandom
                                                     : 32'($urandom_range(0, WORDS * 4 - 1));
         step();
      end

      // Mid-run reset with a non-zero LED value
      drive(MB + 32'h4, 4'hF, 32'h0000_5A3C); step();
      drive(32'h10, 4'h0, 32'h0); step();
      #2 resetn = 1'b0;
      #1;
      check("mid_led", {16'h0, bus.led}, 32'h0);
      check("mid_cnt", dut.cnt_q, 32'h0);
      check("mid_rdata", bus.dm_rdata, 32'h0);
      check("mid_dbg", bus.dbg_rdata, 32'h0);
      check("mid_err", {31'b0, bus.dm_err}, 32'h0);
      ref_cnt = 32'h0; ref_led = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      drive(MB + 32'h4, 4'h0, 32'h0); step();
      check("post_led_rd", bus.dm_rdata, 32'h0);
      drive(MB, 4'h0, 32'h0); step();
      check("post_cnt", bus.dm_rdata, 32'd1);
      drive(32'h10, 4'h0, 32'h0); step();
      check("post_ram", bus.dm_rdata, ref_mem[4]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
